// File: rtl/mat_row_bank_pkg.sv
// Shared types for the matrix row bank: complex element, row and read-bank select encoding.
package mat_row_bank_pkg;

    localparam int MRB_SIZE  = 4;
    localparam int MRB_WIDTH = 64;

    typedef struct packed {
        logic [MRB_WIDTH-1:0] im;
        logic [MRB_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [MRB_SIZE-1:0] row_t;

    typedef enum logic [1:0] {
        RD_SEL_MAT  = 2'd0,
        RD_SEL_L    = 2'd1,
        RD_SEL_U    = 2'd2,
        RD_SEL_RSVD = 2'd3
    } rd_sel_e;

endpackage

// File: rtl/mat_row_bank_ram.sv
// Square 1R1W row store with a registered, read-before-write read port.
// COL_WR=1 turns the write into a column write: wdata element i lands in row i, column waddr.
module mat_row_bank_ram #(
    parameter int DEPTH  = 4,
    parameter int EW     = 128,
    parameter bit COL_WR = 1'b0,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RW    = DEPTH * EW
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [RW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [RW-1:0] rdata
);

    // NOTE: storage is deliberately not reset; only the control path is.
    logic [RW-1:0] mem [DEPTH];

    generate
        if (COL_WR) begin : g_col_wr
            always_ff @(posedge clk_i) begin
                if (we) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i][int'(waddr)*EW +: EW] <= wdata[i*EW +: EW];
                    end
                end
            end
        end else begin : g_row_wr
            always_ff @(posedge clk_i) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

    // NOTE: non-blocking updates make a same-edge write invisible to this read, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mat_row_bank.sv
// Working-matrix, L and U row banks with the LU result collection FSM.
// MAT_ROW_BANK_TRANSPOSE_EN: store l_col_i as column k of L so L reads return row-major rows.
module mat_row_bank
    import mat_row_bank_pkg::*;
#(
    parameter int SIZE  = MRB_SIZE,
    parameter int WIDTH = MRB_WIDTH,
    localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CW   = $clog2(SIZE) + 1,
    localparam int RW   = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    input  logic [RW-1:0] l_col_i,
    input  logic [RW-1:0] u_row_i,
    input  logic [AW-1:0] res_addr_i,
    input  logic          res_valid_i,
    output logic          res_ready_o,
    input  logic [1:0]    rd_sel_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_valid_o,
    input  logic          release_i,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

`ifdef MAT_ROW_BANK_TRANSPOSE_EN
    localparam bit L_COL_WR = 1'b1;
`else
    localparam bit L_COL_WR = 1'b0;
`endif

    logic [1:0]    state_q;
    logic [CW-1:0] count_q;
    logic          res_we;
    logic          rd_valid_q;
    logic [AW-1:0] rd_addr_q;
    rd_sel_e       rd_sel_q;
    logic [RW-1:0] mat_rdata, l_rdata, u_rdata;

    assign res_ready_o = (state_q != ST_FULL);
    assign full_o      = (state_q == ST_FULL);
    assign count_o     = count_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_addr_o   = rd_addr_q;

    // Flush and reset suppress the bank writes as well as the count update.
    assign res_we = res_valid_i & res_ready_o & rst_ni & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (res_valid_i) begin
                        count_q <= count_q + CW'(1);
                        state_q <= (count_q == CW'(SIZE - 1)) ? ST_FULL : ST_COLLECT;
                    end
                end
                ST_FULL: begin
                    if (release_i) begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_sel_q   <= RD_SEL_RSVD;
        end else begin
            rd_valid_q <= rd_addr_valid_i;
            if (rd_addr_valid_i) begin
                rd_addr_q <= rd_addr_i;
                rd_sel_q  <= rd_sel_e'(rd_sel_i);
            end
        end
    end

    // NOTE: the default assignment first keeps this mux free of inferred latches.
    always_comb begin
        rd_row_o = '0;
        if (rd_valid_q) begin
            case (rd_sel_q)
                RD_SEL_MAT: rd_row_o = mat_rdata;
                RD_SEL_L:   rd_row_o = l_rdata;
                RD_SEL_U:   rd_row_o = u_rdata;
                default:    rd_row_o = '0;
            endcase
        end
    end

    mat_row_bank_ram #(.DEPTH(SIZE), .EW(2*WIDTH), .COL_WR(1'b0)) u_mat_ram (
        .clk_i (clk_i),
        .we    (wr_valid_i),
        .waddr (wr_addr_i),
        .wdata (wr_row_i),
        .re    (rd_addr_valid_i),
        .raddr (rd_addr_i),
        .rdata (mat_rdata)
    );

    mat_row_bank_ram #(.DEPTH(SIZE), .EW(2*WIDTH), .COL_WR(L_COL_WR)) u_l_ram (
        .clk_i (clk_i),
        .we    (res_we),
        .waddr (res_addr_i),
        .wdata (l_col_i),
        .re    (rd_addr_valid_i),
        .raddr (rd_addr_i),
        .rdata (l_rdata)
    );

    mat_row_bank_ram #(.DEPTH(SIZE), .EW(2*WIDTH), .COL_WR(1'b0)) u_u_ram (
        .clk_i (clk_i),
        .we    (res_we),
        .waddr (res_addr_i),
        .wdata (u_row_i),
        .re    (rd_addr_valid_i),
        .raddr (rd_addr_i),
        .rdata (u_rdata)
    );

endmodule

// File: tb/tb_mat_row_bank.sv
// Directed bench for mat_row_bank at SIZE=4, WIDTH=64; L expectations follow MAT_ROW_BANK_TRANSPOSE_EN.
module tb_mat_row_bank;
    import mat_row_bank_pkg::*;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = 2;
    localparam int CW    = 3;
    localparam int RW    = SIZE * 2 * WIDTH;

    typedef logic [RW-1:0] vec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic [RW-1:0] wr_row_i;
    logic [AW-1:0] wr_addr_i;
    logic          wr_valid_i;
    logic [RW-1:0] l_col_i;
    logic [RW-1:0] u_row_i;
    logic [AW-1:0] res_addr_i;
    logic          res_valid_i;
    logic          res_ready_o;
    logic [1:0]    rd_sel_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_addr_valid_i;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic          release_i;
    logic          full_o;
    logic [CW-1:0] count_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    mat_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .wr_row_i        (wr_row_i),
        .wr_addr_i       (wr_addr_i),
        .wr_valid_i      (wr_valid_i),
        .l_col_i         (l_col_i),
        .u_row_i         (u_row_i),
        .res_addr_i      (res_addr_i),
        .res_valid_i     (res_valid_i),
        .res_ready_o     (res_ready_o),
        .rd_sel_i        (rd_sel_i),
        .rd_addr_i       (rd_addr_i),
        .rd_addr_valid_i (rd_addr_valid_i),
        .rd_row_o        (rd_row_o),
        .rd_addr_o       (rd_addr_o),
        .rd_valid_o      (rd_valid_o),
        .release_i       (release_i),
        .full_o          (full_o),
        .count_o         (count_o)
    );

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk_row(input real a, input real b, input real c, input real d);
        row_t r;
        r = '0;
        r[0].re = $realtobits(a);
        r[1].re = $realtobits(b);
        r[2].re = $realtobits(c);
        r[3].re = $realtobits(d);
        return r;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic read_row(input logic [1:0] sel, input logic [AW-1:0] addr);
        rd_sel_i        = sel;
        rd_addr_i       = addr;
        rd_addr_valid_i = 1'b1;
        cyc();
        rd_addr_valid_i = 1'b0;
    endtask

    task automatic handshake(input int k, input vec_t l, input vec_t u);
        res_addr_i  = AW'(k);
        l_col_i     = l;
        u_row_i     = u;
        res_valid_i = 1'b1;
        cyc();
        res_valid_i = 1'b0;
    endtask

    initial begin
        vec_t r2, ra, rb, junk;
        vec_t lk [SIZE];
        vec_t uk [SIZE];
        vec_t un [2];

        r2   = mk_row(1.0, 2.0, 3.0, 4.0);
        ra   = mk_row(5.0, 6.0, 7.0, 8.0);
        rb   = mk_row(9.0, 10.0, 11.0, 12.0);
        junk = mk_row(-1.0, -2.0, -3.0, -4.0);
        for (int k = 0; k < SIZE; k++) begin
            lk[k] = mk_row(4.0*k + 1.0, 4.0*k + 2.0, 4.0*k + 3.0, 4.0*k + 4.0);
            uk[k] = mk_row(10.0*k + 1.0, 10.0*k + 2.0, 10.0*k + 3.0, 10.0*k + 4.0);
        end
        un[0] = mk_row(100.0, 101.0, 102.0, 103.0);
        un[1] = mk_row(110.0, 111.0, 112.0, 113.0);

        rst_ni = 1'b0; flush_i = 1'b0; release_i = 1'b0;
        wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
        l_col_i = '0; u_row_i = '0; res_addr_i = '0; res_valid_i = 1'b0;
        rd_sel_i = 2'd0; rd_addr_i = 2'd3; rd_addr_valid_i = 1'b1;
        cyc();
        cyc();
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_row", rd_row_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_count", count_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ready", res_ready_o, 1);
        rst_ni = 1'b1;
        rd_addr_valid_i = 1'b0;
        cyc();

        // Basic write then read of the working matrix.
        wr_addr_i = 2'd2; wr_row_i = r2; wr_valid_i = 1'b1;
        cyc();
        wr_valid_i = 1'b0;
        read_row(2'd0, 2'd2);
        check("mat_row2", rd_row_o, r2);
        check("mat_addr2", rd_addr_o, 2);
        check("mat_valid", rd_valid_o, 1);
        cyc();
        check("idle_valid", rd_valid_o, 0);

        // Read-before-write on a same-cycle collision.
        wr_addr_i = 2'd1; wr_row_i = ra; wr_valid_i = 1'b1;
        cyc();
        wr_row_i = rb;
        read_row(2'd0, 2'd1);
        wr_valid_i = 1'b0;
        check("rbw_old", rd_row_o, ra);
        read_row(2'd0, 2'd1);
        check("rbw_new", rd_row_o, rb);

        // Collect four results.
        for (int k = 0; k < SIZE; k++) begin
            handshake(k, lk[k], uk[k]);
            check($sformatf("count_k%0d", k), count_o, k + 1);
            check($sformatf("full_k%0d", k), full_o, (k == SIZE - 1) ? 1 : 0);
        end
        check("full_ready", res_ready_o, 0);
        handshake(0, junk, junk);
        check("extra_count", count_o, 4);
        check("extra_full", full_o, 1);
        read_row(2'd2, 2'd0);
        check("u_row0_kept", rd_row_o, uk[0]);
        read_row(2'd2, 2'd2);
        check("u_row2", rd_row_o, uk[2]);
`ifdef MAT_ROW_BANK_TRANSPOSE_EN
        read_row(2'd1, 2'd3);
        check("l_row3_t", rd_row_o, mk_row(4.0, 8.0, 12.0, 16.0));
`else
        read_row(2'd1, 2'd0);
        check("l_row0", rd_row_o, mk_row(1.0, 2.0, 3.0, 4.0));
`endif

        // Release from FULL.
        release_i = 1'b1;
        cyc();
        release_i = 1'b0;
        check("rel_count", count_o, 0);
        check("rel_full", full_o, 0);
        check("rel_ready", res_ready_o, 1);

        // Release ignored while collecting; flush wins over a handshake.
        handshake(0, lk[0], un[0]);
        handshake(1, lk[1], un[1]);
        release_i = 1'b1;
        cyc();
        release_i = 1'b0;
        check("rel_ignored", count_o, 2);
        flush_i = 1'b1;
        handshake(2, junk, junk);
        flush_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_ready", res_ready_o, 1);
        check("flush_full", full_o, 0);
        read_row(2'd2, 2'd0);
        check("flush_u0", rd_row_o, un[0]);
        read_row(2'd2, 2'd1);
        check("flush_u1", rd_row_o, un[1]);
        read_row(2'd2, 2'd2);
        check("flush_u2_kept", rd_row_o, uk[2]);

        // Reset mid-collect and mid-read.
        handshake(3, lk[3], uk[3]);
        check("pre_rst_count", count_o, 1);
        rst_ni = 1'b0;
        read_row(2'd0, 2'd2);
        check("mid_rst_valid", rd_valid_o, 0);
        check("mid_rst_row", rd_row_o, 0);
        check("mid_rst_count", count_o, 0);
        rst_ni = 1'b1;
        cyc();

        // Reserved bank reads zero but still responds.
        read_row(2'd3, 2'd1);
        check("rsvd_row", rd_row_o, 0);
        check("rsvd_valid", rd_valid_o, 1);
        check("rsvd_addr", rd_addr_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mat_row_bank.md
MAT_ROW_BANK -- requirements
Module: mat_row_bank

Interface
REQ-001 SIZE, default 4, matrix dimension (rows = columns); SHALL be a power of two, 2..16.
REQ-002 WIDTH, default 64, bits per real or imaginary part (IEEE double).
REQ-003 clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 flush_i  in  1  abort collection; returns FSM to IDLE.
REQ-006 wr_row_i  in  SIZE*2*WIDTH  working-matrix row writeback from LU, element j = {imag,real} at bits [j*2*WIDTH +: 2*WIDTH].
REQ-007 wr_addr_i  in  clog2(SIZE)  writeback row index; wr_valid_i  in  1  writeback strobe.
REQ-008 l_col_i, u_row_i  in  SIZE*2*WIDTH each  LU result column k of L and row k of U.
REQ-009 res_addr_i  in  clog2(SIZE)  k; res_valid_i  in  1; res_ready_o  out  1.
REQ-010 rd_sel_i  in  2  bank select: 0 = working matrix, 1 = L, 2 = U, 3 = reserved (reads zero).
REQ-011 rd_addr_i  in  clog2(SIZE); rd_addr_valid_i  in  1  row read request from LU or triangular inverter.
REQ-012 rd_row_o  out  SIZE*2*WIDTH; rd_addr_o  out  clog2(SIZE); rd_valid_o  out  1  read response.
REQ-013 release_i  in  1  consumer has finished with L/U; full_o  out  1  all SIZE results held; count_o  out  clog2(SIZE)+1  results received.

Function
REQ-014 Read latency SHALL be exactly 1 cycle: request at edge n produces rd_row_o, rd_addr_o = rd_addr_i, rd_valid_o = 1 after edge n+1; rd_valid_o = 0 in cycles with no request.
REQ-015 Reads SHALL be read-before-write: a same-cycle write to the addressed row returns the old contents.
REQ-016 wr_valid_i SHALL always be accepted (no backpressure) and overwrite the whole working-matrix row wr_addr_i.
REQ-017 FSM states IDLE, COLLECT, FULL; res_ready_o = 1 in IDLE and COLLECT, 0 in FULL.
REQ-018 A result handshake (res_valid_i & res_ready_o) SHALL write u_row_i into U row k, store l_col_i into the L bank, and increment count_o; IDLE->COLLECT on the first handshake.
REQ-019 The handshake that brings count_o to SIZE SHALL move COLLECT->FULL; full_o = 1 exactly in FULL.
REQ-020 FULL->IDLE on release_i, with count_o cleared to 0 on the same edge; release_i in IDLE/COLLECT SHALL be ignored.
REQ-021 flush_i SHALL force IDLE and count_o = 0 from any state, with priority over release_i and handshakes; stored data is retained.
REQ-022 SIZE=1 degenerate: first handshake goes IDLE->FULL directly.
REQ-023 Out-of-range or reserved reads (rd_sel_i = 3) SHALL return all-zero data with rd_valid_o = 1.

Reset
REQ-024 When rst_ni = 0 at an edge: state IDLE, count_o = 0, full_o = 0, rd_valid_o = 0, rd_row_o = 0, rd_addr_o = 0; res_ready_o = 1 after reset.
REQ-025 Storage arrays SHALL NOT be reset; reset mid-COLLECT SHALL discard the count.

Configuration
REQ-026 Macro MAT_ROW_BANK_TRANSPOSE_EN defined: l_col_i element i SHALL be written to L row i, column k, so an L read returns the row-major row.
REQ-027 Macro undefined: l_col_i SHALL be stored verbatim at L row k, so an L read returns column k; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the complex-element typedef ({imag,real}, 2*WIDTH), the row typedef (SIZE elements), and the rd_sel encoding enum.
REQ-029 One sub-module, mat_row_bank_ram (1R1W, 1-cycle registered read, read-before-write), SHALL be instantiated three times: matrix, L and U.

Verification
REQ-030 Write row 2 = {1.0+j0, 2.0+j0, ...}, then read sel 0 addr 2 -> next cycle rd_row_o matches, rd_addr_o = 2, rd_valid_o = 1.
REQ-031 Same-cycle write of row 1 with new data and read of row 1 -> old data returned; a read one cycle later -> new data.
REQ-032 Four handshakes k = 0..3 (SIZE=4) -> count_o 1,2,3,4, full_o rises after the 4th, res_ready_o = 0; a 5th res_valid_i is not accepted.
REQ-033 TRANSPOSE_EN, l_col k=0 = {1,2,3,4} (real) -> L read row 3 element 0 = 4.0; without the macro, L read row 0 = {1,2,3,4}.
REQ-034 Flush at count_o = 2 -> state IDLE, count_o = 0, stored U rows 0..1 still readable.
REQ-035 release_i in FULL -> IDLE, count_o = 0, res_ready_o = 1 the next cycle; rst_ni low mid-read -> rd_valid_o = 0 the next cycle.
